// File: rtl/ec_scalar_mult_ctrl.sv
// ec_scalar_mult_ctrl: left-to-right double-and-add sequencer for R = k*P over external dbl/add engines.
// Define ECSM_CONST_TIME_EN for a fixed add handshake on every bit below the MSB (dummy adds discarded).
module ec_scalar_mult_ctrl #(
  parameter int N = 256
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] k,
  input  logic [N-1:0] px,
  input  logic [N-1:0] py,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] rx,
  output logic [N-1:0] ry,
  output logic         r_inf,
  output logic         dbl_start,
  output logic [N-1:0] dbl_x,
  output logic [N-1:0] dbl_y,
  input  logic         dbl_done,
  input  logic [N-1:0] dbl_rx,
  input  logic [N-1:0] dbl_ry,
  input  logic         dbl_inf,
  output logic         add_start,
  output logic [N-1:0] add_x1,
  output logic [N-1:0] add_y1,
  output logic [N-1:0] add_x2,
  output logic [N-1:0] add_y2,
  input  logic         add_done,
  input  logic [N-1:0] add_rx,
  input  logic [N-1:0] add_ry,
  input  logic         add_inf
);
  localparam int W = $clog2(N);
  typedef enum logic [2:0] {IDLE, SCAN, NEXT, DBL, WDBL, CHK, WADD, FIN} state_t;
  typedef enum logic [2:0] {A_NONE, A_LOAD, A_INF, A_DBL, A_ADD} act_t;
  state_t state_q, state_d;
  logic [N-1:0] k_q, k_d, px_q, px_d, py_q, py_d, ax_q, ax_d, ay_q, ay_d, rx_q, rx_d, ry_q, ry_d;
  logic [W-1:0] i_q, i_d;
  logic ainf_q, ainf_d, dadd_q, dadd_d, busy_q, busy_d, done_q, done_d, r_inf_q, r_inf_d;
  logic dbl_start_q, dbl_start_d, add_start_q, add_start_d;
  logic kb;
  act_t act;
`ifdef ECSM_CONST_TIME_EN
  act_t act_q, act_d;
`endif
  assign kb = k_q[i_q];
  // What a set bit does to acc; adding P to +/-P cannot go through the generic add engine
  assign act = !kb ? A_NONE : ainf_q ? A_LOAD : ax_q != px_q ? A_ADD : ay_q == py_q ? A_DBL : A_INF;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    px_d = px_q;
    py_d = py_q;
    ax_d = ax_q;
    ay_d = ay_q;
    i_d = i_q;
    ainf_d = ainf_q;
    dadd_d = dadd_q;
    busy_d = busy_q;
    rx_d = rx_q;
    ry_d = ry_q;
    r_inf_d = r_inf_q;
    done_d = 1'b0;
    dbl_start_d = 1'b0;
    add_start_d = 1'b0;
`ifdef ECSM_CONST_TIME_EN
    act_d = act_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        k_d = k;
        px_d = px;
        py_d = py;
        i_d = W'(N - 1);
        ainf_d = 1'b1;
        busy_d = 1'b1;
        state_d = SCAN;
      end
`ifdef ECSM_CONST_TIME_EN
      SCAN: begin
        if (kb) begin
          ax_d = px_q;
          ay_d = py_q;
          ainf_d = 1'b0;
        end
        state_d = NEXT;
      end
`else
      SCAN: if (kb) begin
        ax_d = px_q;
        ay_d = py_q;
        ainf_d = 1'b0;
        state_d = NEXT;
      end else if (i_q == '0) state_d = FIN;
      else i_d = i_q - 1'b1;
`endif
      NEXT: if (i_q == '0) state_d = FIN;
      else begin
        i_d = i_q - 1'b1;
        dadd_d = 1'b0;
        state_d = DBL;
      end
      DBL: if (ainf_q) state_d = CHK;
      else begin
        dbl_start_d = 1'b1;
        state_d = WDBL;
      end
      WDBL: if (dbl_done) begin
        ax_d = dbl_rx;
        ay_d = dbl_ry;
        ainf_d = dbl_inf;
        state_d = dadd_q ? NEXT : CHK;
      end
`ifdef ECSM_CONST_TIME_EN
      CHK: begin
        act_d = act;
        add_start_d = 1'b1;
        state_d = WADD;
      end
      WADD: if (add_done) begin
        if (act_q == A_ADD) begin
          ax_d = add_rx;
          ay_d = add_ry;
          ainf_d = add_inf;
        end
        if (act_q == A_LOAD) begin
          ax_d = px_q;
          ay_d = py_q;
          ainf_d = 1'b0;
        end
        if (act_q == A_INF) ainf_d = 1'b1;
        dbl_start_d = act_q == A_DBL;
        dadd_d = act_q == A_DBL;
        state_d = act_q == A_DBL ? WDBL : NEXT;
      end
`else
      CHK: if (act == A_ADD) begin
        add_start_d = 1'b1;
        state_d = WADD;
      end else if (act == A_DBL) begin
        dbl_start_d = 1'b1;
        dadd_d = 1'b1;
        state_d = WDBL;
      end else begin
        if (act == A_LOAD) begin
          ax_d = px_q;
          ay_d = py_q;
          ainf_d = 1'b0;
        end
        if (act == A_INF) ainf_d = 1'b1;
        state_d = NEXT;
      end
      WADD: if (add_done) begin
        ax_d = add_rx;
        ay_d = add_ry;
        ainf_d = add_inf;
        state_d = NEXT;
      end
`endif
      FIN: begin
        rx_d = ainf_q ? '0 : ax_q;
        ry_d = ainf_q ? '0 : ay_q;
        r_inf_d = ainf_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      px_q <= '0;
      py_q <= '0;
      ax_q <= '0;
      ay_q <= '0;
      i_q <= '0;
      ainf_q <= 1'b1;
      dadd_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      rx_q <= '0;
      ry_q <= '0;
      r_inf_q <= 1'b0;
      dbl_start_q <= 1'b0;
      add_start_q <= 1'b0;
`ifdef ECSM_CONST_TIME_EN
      act_q <= A_NONE;
`endif
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      px_q <= px_d;
      py_q <= py_d;
      ax_q <= ax_d;
      ay_q <= ay_d;
      i_q <= i_d;
      ainf_q <= ainf_d;
      dadd_q <= dadd_d;
      busy_q <= busy_d;
      done_q <= done_d;
      rx_q <= rx_d;
      ry_q <= ry_d;
      r_inf_q <= r_inf_d;
      dbl_start_q <= dbl_start_d;
      add_start_q <= add_start_d;
`ifdef ECSM_CONST_TIME_EN
      act_q <= act_d;
`endif
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign rx = rx_q;
  assign ry = ry_q;
  assign r_inf = r_inf_q;
  assign dbl_start = dbl_start_q;
  assign dbl_x = ax_q;
  assign dbl_y = ay_q;
  assign add_start = add_start_q;
  assign add_x1 = ax_q;
  assign add_y1 = ay_q;
  assign add_x2 = px_q;
  assign add_y2 = py_q;
endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// tb_ec_scalar_mult_ctrl: scoreboard bench for ec_scalar_mult_ctrl on y^2=x^3+2x+2 mod 17, P=(5,1).
module tb_ec_scalar_mult_ctrl;
  localparam int N = 8;
  logic clk = 1'b0;
  logic reset, start, busy, done, r_inf, dbl_start, dbl_done, dbl_inf, add_start, add_done, add_inf;
  logic [N-1:0] k, px, py, rx, ry, dbl_x, dbl_y, dbl_rx, dbl_ry;
  logic [N-1:0] add_x1, add_y1, add_x2, add_y2, add_rx, add_ry;
  typedef struct {int x; int y; bit inf;} pt_t;
  pt_t exp_q[$];
  int tests = 0, fails = 0, dbl_cnt = 0, add_cnt = 0, done_seen = 0, long_lat = 0;

  always #5 clk = ~clk;

  ec_scalar_mult_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .k(k), .px(px), .py(py),
    .busy(busy), .done(done), .rx(rx), .ry(ry), .r_inf(r_inf),
    .dbl_start(dbl_start), .dbl_x(dbl_x), .dbl_y(dbl_y), .dbl_done(dbl_done),
    .dbl_rx(dbl_rx), .dbl_ry(dbl_ry), .dbl_inf(dbl_inf),
    .add_start(add_start), .add_x1(add_x1), .add_y1(add_y1), .add_x2(add_x2), .add_y2(add_y2),
    .add_done(add_done), .add_rx(add_rx), .add_ry(add_ry), .add_inf(add_inf)
  );

  function automatic int md(int v);
    return ((v % 17) + 17) % 17;
  endfunction

  function automatic int inv(int v);
    int r = 1;
    for (int j = 0; j < 15; j++) r = md(r * v);
    return r;
  endfunction

  // Full group law (handles infinity, inverses and doubling)
  function automatic pt_t padd(pt_t a, pt_t b);
    pt_t r;
    int lam;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x && md(a.y + b.y) == 0) begin
      r.x = 0; r.y = 0; r.inf = 1'b1;
      return r;
    end
    lam = (a.x == b.x) ? md(md(3 * a.x * a.x + 2) * inv(md(2 * a.y)))
                       : md(md(b.y - a.y) * inv(md(b.x - a.x)));
    r.x = md(lam * lam - a.x - b.x);
    r.y = md(lam * (a.x - r.x) - a.y);
    r.inf = 1'b0;
    return r;
  endfunction

  function automatic pt_t ref_mult(int kk);
    pt_t acc, p;
    acc.x = 0; acc.y = 0; acc.inf = 1'b1;
    p.x = 5; p.y = 1; p.inf = 1'b0;
    for (int j = 0; j < kk; j++) acc = padd(acc, p);
    return acc;
  endfunction

  initial begin : dbl_engine
    pt_t a, r;
    int lat;
    dbl_done = 1'b0; dbl_rx = '0; dbl_ry = '0; dbl_inf = 1'b0;
    forever begin
      @(negedge clk);
      if (dbl_start) begin
        a.x = int'(dbl_x); a.y = int'(dbl_y); a.inf = 1'b0;
        lat = long_lat > 0 ? long_lat : int'($urandom_range(1, 4));
        repeat (lat) begin
          @(negedge clk);
          if (dbl_start) begin fails++; $display("FAIL dbl_overlap got=1 exp=0"); end
        end
        r = padd(a, a);
        dbl_rx = r.x[N-1:0]; dbl_ry = r.y[N-1:0]; dbl_inf = r.inf; dbl_done = 1'b1;
        @(negedge clk);
        dbl_done = 1'b0;
      end
    end
  end

  initial begin : add_engine
    pt_t a, b, r;
    int lat;
    add_done = 1'b0; add_rx = '0; add_ry = '0; add_inf = 1'b0;
    forever begin
      @(negedge clk);
      if (add_start) begin
        a.x = int'(add_x1); a.y = int'(add_y1); a.inf = 1'b0;
        b.x = int'(add_x2); b.y = int'(add_y2); b.inf = 1'b0;
        lat = int'($urandom_range(1, 4));
        repeat (lat) begin
          @(negedge clk);
          if (add_start) begin fails++; $display("FAIL add_overlap got=1 exp=0"); end
        end
        r = padd(a, b);
        add_rx = r.x[N-1:0]; add_ry = r.y[N-1:0]; add_inf = r.inf; add_done = 1'b1;
        @(negedge clk);
        add_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (dbl_start) dbl_cnt++;
    if (add_start) add_cnt++;
  end

  always @(negedge clk) begin : monitor
    pt_t e;
    if (done) begin
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done got=(%0d,%0d,%0d) exp=no_done", rx, ry, r_inf);
      end else begin
        e = exp_q.pop_front();
        tests++;
        if (r_inf !== e.inf || int'(rx) != (e.inf ? 0 : e.x) || int'(ry) != (e.inf ? 0 : e.y)) begin
          fails++;
          $display("FAIL result got=(%0d,%0d,inf=%0d) exp=(%0d,%0d,inf=%0d)", rx, ry, r_inf, e.x, e.y, e.inf);
        end
      end
      done_seen++;
    end
  end

  task automatic run(input int kk, input pt_t e, input bit inj, input int exp_dbl, input int exp_add);
    int d0, a0, s0, t;
    t = 0;
    while (busy && t < 5000) begin @(negedge clk); t++; end
    @(negedge clk);
    d0 = dbl_cnt; a0 = add_cnt; s0 = done_seen;
    start = 1'b1; k = kk[N-1:0]; px = 8'd5; py = 8'd1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (busy !== 1'b1) begin fails++; $display("FAIL busy_after_start k=%0d got=%0b exp=1", kk, busy); end
    if (inj) begin
      repeat (2) @(negedge clk);
      if (busy) begin
        start = 1'b1; k = ~kk[N-1:0];
        @(negedge clk);
        start = 1'b0;
      end
    end
    t = 0;
    while (done_seen == s0 && t < 3000) begin @(negedge clk); t++; end
    if (done_seen == s0) begin
      fails++;
      void'(exp_q.pop_front());
      $display("FAIL done_timeout k=%0d got=no_done exp=done", kk);
    end
    if (exp_dbl >= 0) begin
      tests++;
      if (dbl_cnt - d0 != exp_dbl) begin fails++; $display("FAIL dbl_count k=%0d got=%0d exp=%0d", kk, dbl_cnt - d0, exp_dbl); end
    end
    if (exp_add >= 0) begin
      tests++;
      if (add_cnt - a0 != exp_add) begin fails++; $display("FAIL add_count k=%0d got=%0d exp=%0d", kk, add_cnt - a0, exp_add); end
    end
  endtask

  int dk[6] = '{1, 2, 5, 18, 19, 0};
  pt_t de[6] = '{'{5, 1, 1'b0}, '{6, 3, 1'b0}, '{9, 16, 1'b0}, '{5, 16, 1'b0}, '{0, 0, 1'b1}, '{0, 0, 1'b1}};
  int ed[6] = '{0, 1, 2, 4, 4, 0};
`ifdef ECSM_CONST_TIME_EN
  int ea[6] = '{7, 7, 7, 7, 7, 7};
`else
  int ea[6] = '{0, 0, 1, 1, 1, 0};
`endif

  initial begin
    int kk, t, s0;
    reset = 1'b1; start = 1'b0; k = '0; px = '0; py = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({busy, done, rx, ry, r_inf, dbl_start, add_start} !== '0) begin
      fails++;
      $display("FAIL reset_state got=%0b/%0b/%0d/%0d/%0b/%0b/%0b exp=all_zero", busy, done, rx, ry, r_inf, dbl_start, add_start);
    end
    reset = 1'b0;
    for (int j = 0; j < 6; j++) run(dk[j], de[j], 1'b0, ed[j], ea[j]);
    run(5, de[2], 1'b1, -1, -1);
    // Reset while waiting on the doubler; its late done must be ignored
    long_lat = 8;
    @(negedge clk);
    start = 1'b1; k = 8'd2; px = 8'd5; py = 8'd1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!dbl_start && t < 500) begin @(negedge clk); t++; end
    tests++;
    if (!dbl_start) begin fails++; $display("FAIL wait_dbl_start got=none exp=dbl_start"); end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    s0 = done_seen;
    repeat (15) @(negedge clk);
    long_lat = 0;
    tests++;
    if (done_seen != s0 || busy !== 1'b0 || rx !== '0 || ry !== '0) begin
      fails++;
      $display("FAIL mid_reset got=dones:%0d busy:%0b rx:%0d ry:%0d exp=dones:0 busy:0 rx:0 ry:0", done_seen - s0, busy, rx, ry);
    end
    run(2, de[1], 1'b0, 1, ea[1]);
    for (int j = 0; j < 20; j++) begin
      kk = int'($urandom_range(0, 255));
      run(kk, ref_mult(kk), 1'(j % 2), -1, -1);
    end
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
